// File: rtl/calc_op_sequencer.sv
// Multi-cycle calculator controller: one command in, one result out, with
// add/sub/shift-add multiply/restoring divide all sharing a single adder.
module calc_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 res_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_res_valid;
    logic [2*WIDTH-1:0]   r_res_data;
    logic                 r_res_err;

    logic [WIDTH:0]       w_add_x;
    logic [WIDTH:0]       w_add_y;
    logic                 w_add_cin;
    logic [WIDTH+1:0]     w_sum;
    logic                 w_no_borrow;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_addsub_res;

    // Subtraction (SUB and the divide trial step) is x + ~y + 1, so bit
    // WIDTH+1 of the sum is the "no borrow" indication.
    always_comb begin
        w_add_x   = '0;
        w_add_y   = '0;
        w_add_cin = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_add_x = {1'b0, r_a};
                w_add_y = {1'b0, r_b};
            end
            OP_SUB: begin
                w_add_x   = {1'b0, r_a};
                w_add_y   = ~{1'b0, r_b};
                w_add_cin = 1'b1;
            end
            OP_MUL: begin
                w_add_x = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
                w_add_y = r_acc[0] ? {1'b0, r_a} : '0;
            end
            default: begin
                w_add_x   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
                w_add_y   = ~{1'b0, r_b};
                w_add_cin = 1'b1;
            end
        endcase
    end

    assign w_sum       = {1'b0, w_add_x} + {1'b0, w_add_y} + {{(WIDTH+1){1'b0}}, w_add_cin};
    assign w_no_borrow = w_sum[WIDTH+1];

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    assign w_mul_next = {w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; restore by keeping the shifted value.
    assign w_div_next = {(w_no_borrow ? w_sum[WIDTH-1:0]
                                      : {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]}),
                         r_acc[WIDTH-2:0], w_no_borrow};
    assign w_acc_next = r_op[0] ? w_div_next : w_mul_next;

    assign w_addsub_res = r_op[0]
        ? {{(WIDTH-1){1'b0}}, ~w_no_borrow, w_sum[WIDTH-1:0]}
        : {{(WIDTH-1){1'b0}}, w_sum[WIDTH:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_a   <= cmd_a;
                        r_b   <= cmd_b;
                        r_cnt <= '0;
                        if (cmd_op == OP_DIV && cmd_b == '0) begin
                            r_acc       <= '0;
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                            r_res_data  <= '0;
                            r_res_err   <= 1'b1;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, (cmd_op == OP_DIV) ? cmd_a : cmd_b};
                            r_state <= S_EXEC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (!r_op[1]) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_addsub_res;
                        r_res_err   <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == LAST_STEP) begin
                            r_cnt       <= '0;
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_res_valid <= 1'b1;
                            r_res_data  <= w_acc_next;
                            r_res_err   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: table of commands with hand-computed
// results and latencies, plus backpressure and reset-abort sequences.
module tb_calc_op_sequencer;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    calc_op_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;   // edges counted from and including the accept edge
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one command, garbles cmd_* during execution, waits for the result, then accepts it.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] data, output logic err, output int lat,
                           output int busy_n, output bit ready_low_ok);
        int guard;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_op = ~op; cmd_a = ~a; cmd_b = 8'h00;
        lat = 1; busy_n = 0; ready_low_ok = 1'b1;
        while (!res_valid && lat < 40) begin
            if (busy) busy_n++;
            if (cmd_ready) ready_low_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        data = res_data;
        err  = res_err;
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("res_valid_clear", 32'(res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        e;
        int          lat;
        int          bn;
        bit          rok;
        bit          seen;
        int          guard;

        vecs[0]  = '{OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b0, 2};
        vecs[1]  = '{OP_ADD, 8'd255, 8'd255, 16'h01FE, 1'b0, 2};
        vecs[2]  = '{OP_ADD, 8'd0,   8'd0,   16'h0000, 1'b0, 2};
        vecs[3]  = '{OP_SUB, 8'd5,   8'd7,   16'h01FE, 1'b0, 2};
        vecs[4]  = '{OP_SUB, 8'd200, 8'd100, 16'h0064, 1'b0, 2};
        vecs[5]  = '{OP_SUB, 8'd7,   8'd7,   16'h0000, 1'b0, 2};
        vecs[6]  = '{OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 9};
        vecs[7]  = '{OP_MUL, 8'd3,   8'd4,   16'h000C, 1'b0, 9};
        vecs[8]  = '{OP_MUL, 8'd0,   8'd123, 16'h0000, 1'b0, 9};
        vecs[9]  = '{OP_MUL, 8'd16,  8'd16,  16'h0100, 1'b0, 9};
        vecs[10] = '{OP_DIV, 8'd200, 8'd7,   16'h041C, 1'b0, 9};
        vecs[11] = '{OP_DIV, 8'd255, 8'd1,   16'h00FF, 1'b0, 9};
        vecs[12] = '{OP_DIV, 8'd5,   8'd9,   16'h0500, 1'b0, 9};
        vecs[13] = '{OP_DIV, 8'd9,   8'd0,   16'h0000, 1'b1, 1};
        vecs[14] = '{OP_DIV, 8'd255, 8'd16,  16'h0F0F, 1'b0, 9};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00; res_ready = 1'b0;
        #12;
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_data",  32'(res_data),  32'd0);
        chk("reset_res_err",   32'(res_err),   32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, d, e, lat, bn, rok);
            $display("[TB] vec %0d op=%0d a=%0d b=%0d -> data=0x%04h err=%0b lat=%0d busy=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, d, e, lat, bn);
            chk($sformatf("vec%0d_data", i),      32'(d),   32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_err", i),       32'(e),   32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i),   32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'(vecs[i].exp_lat - 1));
            chk($sformatf("vec%0d_ready_low", i), 32'(rok), 32'd1);
        end

        // Backpressure: MUL 3*4 held for 10 cycles while an ADD is already pending.
        @(negedge clk);
        cmd_op = OP_MUL; cmd_a = 8'd3; cmd_b = 8'd4; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_op = OP_ADD; cmd_a = 8'd10; cmd_b = 8'd20;
        guard = 0;
        while (!res_valid && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("bp_mul_done", 32'(res_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid_c%0d", c), 32'(res_valid), 32'd1);
            chk($sformatf("bp_data_c%0d", c),  32'(res_data),  32'h000C);
            chk($sformatf("bp_ready_c%0d", c), 32'(cmd_ready), 32'd0);
        end
        $display("[TB] backpressure MUL 3*4 held: data=0x%04h", res_data);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("bp_handshake_valid", 32'(res_valid), 32'd0);
        chk("bp_handshake_ready", 32'(cmd_ready), 32'd1);
        chk("bp_no_same_cycle_accept", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_next_accepted", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        guard = 0;
        while (!res_valid && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("bp_add_data", 32'(res_data), 32'h001E);
        $display("[TB] pending ADD 10+20 -> data=0x%04h", res_data);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;

        // Reset abort in the middle of a multiply.
        @(negedge clk);
        cmd_op = OP_MUL; cmd_a = 8'd255; cmd_b = 8'd255; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_res_data",  32'(res_data),  32'd0);
        chk("abort_res_err",   32'(res_err),   32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (res_valid || busy) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        $display("[TB] reset abort during MUL: res_valid/busy seen afterwards=%0b", seen);
        run_cmd(OP_ADD, 8'd200, 8'd100, d, e, lat, bn, rok);
        $display("[TB] post-abort ADD 200+100 -> data=0x%04h err=%0b lat=%0d", d, e, lat);
        chk("post_abort_data", 32'(d),   32'h012C);
        chk("post_abort_err",  32'(e),   32'd0);
        chk("post_abort_lat",  32'(lat), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
